// File: rtl/cu_array_cacheline_request_generator.sv
// Splits one array job {base, count} into 128-byte-aligned cacheline read commands with per-line element windows.
// Optional CU_REQ_STATS_EN adds handshake and stall counters.
module cu_array_cacheline_request_generator #(
   parameter logic [7:0] CU_ID           = 8'h01,  // VERTEX_CONTROL_ID
   parameter int         ELEMENT_SIZE    = 4,
   parameter int         CACHELINE_BYTES = 128,
   parameter int         COUNT_BITS      = 32,
   localparam int        EPL             = CACHELINE_BYTES / ELEMENT_SIZE,
   localparam int        IDXW            = $clog2(EPL),
   localparam int        NUMW            = IDXW + 1
) (
   input  logic                  clock,
   input  logic                  rstn,
   input  logic                  enabled_in,
   input  logic                  job_valid_in,
   output logic                  job_ready_out,
   input  logic [63:0]           job_base_addr_in,
   input  logic [COUNT_BITS-1:0] job_num_elements_in,
   output logic                  cmd_valid_out,
   input  logic                  cmd_ready_in,
   output logic [63:0]           cmd_address_out,
   output logic [IDXW-1:0]       cmd_first_element_out,
   output logic [NUMW-1:0]       cmd_num_elements_out,
   output logic                  cmd_last_out,
   output logic [7:0]            cmd_cu_id_out,
`ifdef CU_REQ_STATS_EN
   output logic [31:0]           stat_cmds_out,
   output logic [31:0]           stat_stall_cycles_out,
`endif
   output logic                  job_done_out
);

   localparam int          LINE_BITS  = $clog2(CACHELINE_BYTES);
   localparam int          EL_BITS    = $clog2(ELEMENT_SIZE);
   localparam logic [63:0] ALIGN_MASK = ~64'(CACHELINE_BYTES - 1);
   localparam logic [63:0] LINE_INC   = 64'(CACHELINE_BYTES);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_DONE} state_t;

   state_t                state_q;
   logic [63:0]           line_addr_q;
   logic [IDXW-1:0]       first_idx_q;
   logic [COUNT_BITS-1:0] remaining_q;
   logic                  cmd_valid_q;
   logic [63:0]           cmd_addr_q;
   logic [IDXW-1:0]       cmd_first_q;
   logic [NUMW-1:0]       cmd_num_q;
   logic                  cmd_last_q;
   logic [7:0]            cu_id_q;
   logic                  done_q;

   logic [NUMW-1:0]       avail_d;
   logic [NUMW-1:0]       first_num_d;
   logic [COUNT_BITS-1:0] rem_after_d;
   logic [NUMW-1:0]       next_num_d;

   function automatic logic [NUMW-1:0] calc_num(input logic [COUNT_BITS-1:0] rem,
                                                input logic [NUMW-1:0]       avail);
      if (rem < COUNT_BITS'(avail)) calc_num = rem[NUMW-1:0];
      else                          calc_num = avail;
   endfunction

   // Window of the first line depends on the start offset; later lines always start at element 0.
   assign avail_d     = NUMW'(EPL) - NUMW'(first_idx_q);
   assign first_num_d = calc_num(remaining_q, avail_d);
   assign rem_after_d = remaining_q - COUNT_BITS'(cmd_num_q);
   assign next_num_d  = calc_num(rem_after_d, NUMW'(EPL));

   assign job_ready_out = rstn && (state_q == S_IDLE) && enabled_in;

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         line_addr_q <= '0;
         first_idx_q <= '0;
         remaining_q <= '0;
         cmd_valid_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_first_q <= '0;
         cmd_num_q   <= '0;
         cmd_last_q  <= 1'b0;
         cu_id_q     <= '0;
         done_q      <= 1'b0;
      end else begin
         cu_id_q <= CU_ID;
         case (state_q)
            S_IDLE: begin
               if (job_valid_in && job_ready_out) begin
                  line_addr_q <= job_base_addr_in & ALIGN_MASK;
                  first_idx_q <= job_base_addr_in[LINE_BITS-1:EL_BITS];
                  remaining_q <= job_num_elements_in;
                  state_q     <= S_CALC;
               end
            end
            S_CALC: begin
               if (remaining_q == '0) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  cmd_valid_q <= 1'b1;
                  cmd_addr_q  <= line_addr_q;
                  cmd_first_q <= first_idx_q;
                  cmd_num_q   <= first_num_d;
                  cmd_last_q  <= (remaining_q == COUNT_BITS'(first_num_d));
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cmd_ready_in) begin
                  if (cmd_last_q) begin
                     cmd_valid_q <= 1'b0;
                     cmd_addr_q  <= '0;
                     cmd_first_q <= '0;
                     cmd_num_q   <= '0;
                     cmd_last_q  <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     // Load the following line on the handshake edge so commands stream back-to-back.
                     remaining_q <= rem_after_d;
                     line_addr_q <= line_addr_q + LINE_INC;
                     first_idx_q <= '0;
                     cmd_addr_q  <= line_addr_q + LINE_INC;
                     cmd_first_q <= '0;
                     cmd_num_q   <= next_num_d;
                     cmd_last_q  <= (rem_after_d == COUNT_BITS'(next_num_d));
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cmd_valid_out         = cmd_valid_q;
   assign cmd_address_out       = cmd_addr_q;
   assign cmd_first_element_out = cmd_first_q;
   assign cmd_num_elements_out  = cmd_num_q;
   assign cmd_last_out          = cmd_last_q;
   assign cmd_cu_id_out         = cu_id_q;
   assign job_done_out          = done_q;

`ifdef CU_REQ_STATS_EN
   logic [31:0] stat_cmds_q;
   logic [31:0] stat_stall_q;

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         stat_cmds_q  <= '0;
         stat_stall_q <= '0;
      end else if (cmd_valid_q) begin
         if (cmd_ready_in) stat_cmds_q  <= stat_cmds_q + 32'd1;
         else              stat_stall_q <= stat_stall_q + 32'd1;
      end
   end

   assign stat_cmds_out         = stat_cmds_q;
   assign stat_stall_cycles_out = stat_stall_q;
`endif

endmodule
